// File: rtl/shift_deser_if.sv
// rtl/shift_deser_if.sv - serial input and parallel output bundle for shift_deser
// Ports (slave = receiver side):
//   serialIn, bitEn : serial line and bit strobe into the receiver
//   q, valid, ready : parallel word and its valid/ready handshake
//   frameErr, overrun : one-cycle status pulses from the receiver
interface shift_deser_if #(
    parameter int N = 4
) ();
    logic         serialIn;
    logic         bitEn;
    logic [N-1:0] q;
    logic         valid;
    logic         ready;
    logic         frameErr;
    logic         overrun;

    modport slave (
        input  serialIn,
        input  bitEn,
        input  ready,
        output q,
        output valid,
        output frameErr,
        output overrun
    );

    modport master (
        output serialIn,
        output bitEn,
        output ready,
        input  q,
        input  valid,
        input  frameErr,
        input  overrun
    );
endinterface

// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial-to-parallel frame receiver with a one-word output buffer
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : shift_deser_if.slave (serialIn/bitEn in, q/valid/ready handshake, frameErr/overrun pulses)
module shift_deser #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_deser_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  q_q, q_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = q_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Consumption runs independently of bitEn; a word landing below
        // on the same edge overrides this clear.
        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.bitEn && !bus.serialIn) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bus.bitEn) begin
                    sr_d  = {sr_q[N-2:0], bus.serialIn};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bus.bitEn) begin
                    // A 0 stop bit returns to IDLE; it is never reused as a start bit.
                    state_d = IDLE;
                    if (bus.serialIn) begin
                        if (!valid_q || bus.ready) begin
                            q_d     = sr_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.q        = q_q;
    assign bus.valid    = valid_q;
    assign bus.frameErr = ferr_q;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - directed self-checking bench for shift_deser (N=4)
module tb_shift_deser;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    shift_deser_if #(.N(4)) bus ();

    shift_deser #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs away from the edge, clock one edge, settle past it.
    task automatic step(input logic b, input logic en, input logic rdy);
        @(negedge clk);
        bus.serialIn = b;
        bus.bitEn    = en;
        bus.ready    = rdy;
        @(posedge clk);
        #1;
    endtask

    // Start, data MSB first, stop; ready only on the stop edge if rdy_stop.
    task automatic send_frame(input logic [3:0] d, input logic stop_bit, input logic rdy_stop);
        logic [3:0] w;
        w = d;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) step(w[i], 1'b1, 1'b0);
        step(stop_bit, 1'b1, rdy_stop);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.q !== 4'b0000 || bus.valid !== 1'b0 || bus.frameErr !== 1'b0 || bus.overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: q=%b valid=%b ferr=%b ovr=%b expected 0000 0 0 0", bus.q, bus.valid, bus.frameErr, bus.overrun);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (bus.q !== 4'b0000 || bus.valid !== 1'b0 || bus.frameErr !== 1'b0 || bus.overrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: q=%b valid=%b ferr=%b ovr=%b expected 0000 0 0 0", bus.q, bus.valid, bus.frameErr, bus.overrun);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        seq = 6'b001101;
        for (int i = 5; i >= 0; i--) begin
            step(seq[i], 1'b1, 1'b0);
            if (i == 1) begin
                checks++;
                if (bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: got %b expected 0", bus.valid);
                end
            end
        end
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b0110) begin
            errors++;
            $display("FAIL basic_word: valid=%b q=%b expected 1 0110", bus.valid, bus.q);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b0110) begin
            errors++;
            $display("FAIL basic_hold: valid=%b q=%b expected 1 0110", bus.valid, bus.q);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume: valid=%b expected 0", bus.valid);
        end
    endtask

    task automatic test_gating();
        logic [5:0] seq;
        seq = 6'b001101;
        for (int i = 5; i >= 0; i--) begin
            step(seq[i], 1'b1, 1'b0);
            if (i != 0) begin
                // Disabled edge carries the wrong level; it must be ignored.
                step(~seq[i], 1'b0, 1'b0);
                if (i == 1) begin
                    checks++;
                    if (bus.valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gating_early_valid: got %b expected 0 after edge 10", bus.valid);
                    end
                end
            end
        end
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b0110) begin
            errors++;
            $display("FAIL gating_word: valid=%b q=%b expected 1 0110", bus.valid, bus.q);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL gating_consume: valid=%b expected 0 (handshake with bitEn=0)", bus.valid);
        end
    endtask

    task automatic test_frame_err();
        send_frame(4'b1011, 1'b0, 1'b0);
        checks++;
        if (bus.frameErr !== 1'b1 || bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: ferr=%b valid=%b ovr=%b expected 1 0 0", bus.frameErr, bus.valid, bus.overrun);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.frameErr !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_one_cycle: ferr=%b valid=%b expected 0 0", bus.frameErr, bus.valid);
        end
        send_frame(4'b1111, 1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b1111 || bus.frameErr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_recover: valid=%b q=%b ferr=%b expected 1 1111 0", bus.valid, bus.q, bus.frameErr);
        end
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        send_frame(4'b0110, 1'b1, 1'b0);
        send_frame(4'b1001, 1'b1, 1'b0);
        checks++;
        if (bus.overrun !== 1'b1 || bus.q !== 4'b0110 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pulse: ovr=%b q=%b valid=%b expected 1 0110 1", bus.overrun, bus.q, bus.valid);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.overrun !== 1'b0 || bus.q !== 4'b0110 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_one_cycle: ovr=%b q=%b valid=%b expected 0 0110 1", bus.overrun, bus.q, bus.valid);
        end
        send_frame(4'b1001, 1'b1, 1'b1);
        checks++;
        if (bus.overrun !== 1'b0 || bus.q !== 4'b1001 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_consume_land: ovr=%b q=%b valid=%b expected 0 1001 1", bus.overrun, bus.q, bus.valid);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: valid=%b expected 0", bus.valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] a;
        logic [5:0] b;
        a = 6'b011001;
        b = 6'b000111;
        for (int i = 5; i >= 0; i--) step(a[i], 1'b1, 1'b1);
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_first: valid=%b q=%b expected 1 1100", bus.valid, bus.q);
        end
        for (int i = 5; i >= 0; i--) begin
            step(b[i], 1'b1, 1'b1);
            if (i == 5) begin
                checks++;
                if (bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_consumed: valid=%b expected 0", bus.valid);
                end
            end
        end
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b0011 || bus.frameErr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b q=%b ferr=%b expected 1 0011 0", bus.valid, bus.q, bus.frameErr);
        end
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        reset_n = 1'b1;
        checks++;
        if (bus.q !== 4'b0000 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: q=%b valid=%b expected 0000 0", bus.q, bus.valid);
        end
        send_frame(4'b1010, 1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.q !== 4'b1010 || bus.frameErr !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_frame: valid=%b q=%b ferr=%b ovr=%b expected 1 1010 0 0", bus.valid, bus.q, bus.frameErr, bus.overrun);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.serialIn = 1'b1;
        bus.bitEn    = 1'b0;
        bus.ready    = 1'b0;
        test_reset();
        test_basic();
        test_gating();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel frame receiver forming the receive end of the `shiftReg` serial link: a `shiftReg` loaded with a word and shifted MSB-first drives `serialIn` here. The block detects a start bit, assembles N data bits into a parallel word, and checks the stop bit. It presents the word on a valid/ready output with a one-word holding buffer, and flags framing errors and overruns.

## Interface
- N, 4: data word width in bits; N ≥ 2.
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising `clk`.
- serialIn  input  1  serial line; idle level 1.
- bitEn  input  1  bit strobe; `serialIn` is sampled only on edges where `bitEn`=1.
- q  output  N  received word; valid only while `valid`=1.
- valid  output  1  `q` holds an unconsumed word.
- ready  input  1  consumer accepts `q` on an edge where `valid`=1 and `ready`=1.
- frameErr  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: complete frame dropped because the buffer was full.

## Operation
- Frame format on sampled bits: start bit 0, then N data bits MSB first, then stop bit 1.
- Internal state:
  - FSM state IDLE/DATA/STOP.
  - Shift register `sr[N-1:0]`.
  - Bit counter, width $clog2(N+1).
- IDLE:
  - On `bitEn`=1 and `serialIn`=0, go to DATA and clear the counter.
  - A sampled 1 stays in IDLE.
- DATA:
  - On each `bitEn`=1, `sr <= {sr[N-2:0], serialIn}` and the counter increments.
  - When the N-th bit is captured (counter reaches N-1 before the increment), go to STOP.
- STOP, on `bitEn`=1, always return to IDLE, with one of three outcomes:
  - `serialIn`=1 and buffer free: `q <= sr`, `valid <= 1`. The buffer is free if `valid`=0, or `valid`=1 and `ready`=1 on the same edge.
  - `serialIn`=1 and buffer full: `q` and `valid` unchanged, `overrun` pulses 1 for one cycle, and the word is discarded.
  - `serialIn`=0: `frameErr` pulses 1 for one cycle, the word is discarded, and `q`/`valid` are untouched.
- A stop bit of 0 is not treated as a new start bit. The FSM returns to IDLE and the next sampled 0 starts a frame.
- Output handshake:
  - `q` is stable while `valid`=1 and `ready`=0.
  - On `valid`=1 and `ready`=1 with no new word landing, `valid` goes to 0 next cycle.
  - If a new word lands on the consuming edge, `valid` stays 1 and `q` updates to the new word.
- `bitEn`=0 freezes FSM, counter and `sr`. The handshake still operates.
- Reset (synchronous, any state, including mid-frame):
  - FSM → IDLE; counter, `sr`, `q` → 0.
  - `valid`, `frameErr`, `overrun` → 0.
  - Any partial frame is abandoned.

## Timing
- Outputs are registered with no combinational path from inputs to outputs.
- Latency: `valid` rises in the cycle after the edge that samples the stop bit.
- With `bitEn` held at 1, a frame spans N+2 edges, and `valid` is seen N+2 cycles after the start bit is present at an edge.
- `frameErr` and `overrun` are high for exactly one cycle, the cycle after the stop-bit edge.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop bit.
- Throughput: one word per N+2 `bitEn` strobes.
- `ready` is ignored while `valid`=0.

## Test plan
- Reset/idle:
  - Stimulus: hold `reset_n`=0 for 2 cycles, then 1, with `serialIn`=1 and `bitEn`=1.
  - Required: `q`=0000, `valid`=0, `frameErr`=0, `overrun`=0 throughout; no frame starts.
- Basic receive, N=4:
  - Stimulus: `ready`=0, `bitEn`=1; sample sequence 0,0,1,1,0,1 on consecutive edges.
  - Required: `valid`=1 and `q`=0110 on the cycle after the 6th edge, held until `ready`=1 is sampled; `valid`=0 the following cycle.
- Bit-enable gating:
  - Stimulus: same frame as basic receive, with `bitEn` alternating 1,0.
  - Required: `q`=0110, and `valid` rises after the 6th enabled edge (11 edges total).
- Framing error:
  - Stimulus: 0,1,0,1,1 followed by stop bit 0.
  - Required: `frameErr` high for one cycle, `valid` remains 0.
  - Follow-up: the next frame 0,1,1,1,1,1 gives `q`=1111, `valid`=1.
- Overrun:
  - Stimulus: with `ready`=0, receive 0110 and then a second frame 1001.
  - Required: `overrun` pulses once; `q` stays 0110 and `valid` stays 1.
  - Variant: with `ready`=1 asserted on the second stop-bit edge, `q` becomes 1001 with no overrun and `valid` stays 1.
- Reset mid-frame:
  - Stimulus: start a frame with 0,1,0; pulse `reset_n`=0 for one edge; then send 0,1,0,1,0,1.
  - Required: no output from the partial frame; `q`=1010, `valid`=1.
